ata_pio_device: RTL

ATA_PIO_DEVICE -- requirements
Module: ata_pio_device

---
 rtl/ata_pio_device.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ata_pio_device.sv
// ata_pio_device: ATA PIO task-file device with synchronized host strobes and a sector-buffer backend handshake.
module ata_pio_device (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        CS0n,
  input  logic        CS1n,
  input  logic [2:0]  DA,
  input  logic        DIORn,
  input  logic        DIOWn,
  input  logic [15:0] DD_IN,
  output logic [15:0] DD_OUT,
  output logic        DD_OE,
  output logic        INTRQ,
  input  logic [15:0] BUF_RDATA,
  output logic        BUF_POP,
  output logic [15:0] BUF_WDATA,
  output logic        BUF_PUSH,
  output logic        CMD_STB,
  output logic        CMD_WR,
  output logic [27:0] LBA,
  output logic [8:0]  SEC_CNT,
  input  logic        SECT_RDY,
  output logic        SECT_REQ
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRQ, WR_DRQ, WR_WAIT, SRST} state_t;
  state_t state, state_n;
  logic [22:0] s1, s2, s3;
  logic [7:0] count, lba_lo, lba_mid, lba_hi, device, error, word_cnt, tf_reg, status;
  logic nien, pending, err, bsy, drq, drdy;
  logic cs0_s, cs1_s, wr_edge, rd_edge, devctl_wr, srst_on, srst_off, tf_wr, cmd_wr, known, cmd_go;
  logic data_rd, data_wr, xfer, wrap, stat_rd, pend_set, pend_clr;
  logic [2:0] da_s;
  logic [15:0] dd_s;
  // Stage layout: {CS0n, CS1n, DA[2:0], DIORn, DIOWn, DD_IN[15:0]}
  assign cs0_s = !s3[22] && s3[21];
  assign cs1_s = s3[22] && !s3[21];
  assign da_s = s3[20:18];
  assign dd_s = s3[15:0];
  assign rd_edge = s2[17] && !s3[17];
  assign wr_edge = s2[16] && !s3[16];
  assign bsy = state inside {RD_WAIT, WR_WAIT, SRST};
  assign drq = state inside {RD_DRQ, WR_DRQ};
  assign drdy = state != SRST;
  assign status = {bsy, drdy, 1'b0, 1'b1, drq, 2'b00, err};
  assign devctl_wr = wr_edge && cs1_s && da_s == 3'd6;
  assign srst_on = devctl_wr && dd_s[2];
  assign srst_off = devctl_wr && !dd_s[2] && state == SRST;
  assign tf_wr = wr_edge && cs0_s && !bsy && !drq;
  assign cmd_wr = tf_wr && da_s == 3'd7;
  assign known = dd_s[7:0] == 8'h20 || dd_s[7:0] == 8'h30;
  assign cmd_go = cmd_wr && known;
  assign data_rd = rd_edge && cs0_s && da_s == 3'd0 && state == RD_DRQ;
  assign data_wr = wr_edge && cs0_s && da_s == 3'd0 && state == WR_DRQ;
  assign xfer = data_rd || data_wr;
  assign wrap = xfer && word_cnt == 8'hFF;
  assign stat_rd = rd_edge && cs0_s && da_s == 3'd7;
  assign pend_set = (cmd_wr && !known) || wrap;
  assign pend_clr = cmd_wr || stat_rd || srst_on;
  assign DD_OE = !DIORn && (CS0n ^ CS1n);
  assign INTRQ = pending && !nien;
  always_comb begin
    tf_reg = status;
    case (DA)
      3'd1: tf_reg = error;
      3'd2: tf_reg = count;
      3'd3: tf_reg = lba_lo;
      3'd4: tf_reg = lba_mid;
      3'd5: tf_reg = lba_hi;
      3'd6: tf_reg = device;
      default: tf_reg = status;
    endcase
    DD_OUT = (!CS0n && CS1n) ? (DA == 3'd0 ? (drq ? BUF_RDATA : 16'h0000) : {8'h00, tf_reg})
           : (CS0n && !CS1n && DA == 3'd6) ? {8'h00, status} : 16'h00FF;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !cmd_go ? IDLE : dd_s[7:0] == 8'h30 ? WR_DRQ : RD_WAIT;
      RD_WAIT: state_n = SECT_RDY ? RD_DRQ : RD_WAIT;
      RD_DRQ:  state_n = !wrap ? RD_DRQ : SEC_CNT != 9'd1 ? RD_WAIT : IDLE;
      WR_DRQ:  state_n = wrap ? WR_WAIT : WR_DRQ;
      WR_WAIT: state_n = !SECT_RDY ? WR_WAIT : SEC_CNT != 9'd0 ? WR_DRQ : IDLE;
      default: state_n = state;
    endcase
    if (srst_on) state_n = SRST;
    else if (srst_off) state_n = IDLE;
  end
  always_ff @(posedge CLK40)
    if (!RESETn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
      {count, lba_lo, lba_mid, lba_hi, device, error} <= {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
      nien <= 1'b0;
      pending <= 1'b0;
      err <= 1'b0;
      word_cnt <= 8'h00;
      SEC_CNT <= 9'd0;
      LBA <= 28'd0;
      CMD_WR <= 1'b0;
      CMD_STB <= 1'b0;
      BUF_POP <= 1'b0;
      BUF_PUSH <= 1'b0;
      BUF_WDATA <= 16'h0000;
      SECT_REQ <= 1'b0;
    end else begin
      s1 <= {CS0n, CS1n, DA, DIORn, DIOWn, DD_IN};
      s2 <= s1;
      s3 <= s2;
      CMD_STB <= cmd_go;
      BUF_POP <= data_rd;
      BUF_PUSH <= data_wr;
      SECT_REQ <= wrap;
      if (data_wr) BUF_WDATA <= dd_s;
      if (devctl_wr) nien <= dd_s[1];
      if (srst_off) begin
        {count, lba_lo, lba_mid, lba_hi, device, error} <= {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        err <= 1'b0;
      end else if (tf_wr) begin
        case (da_s)
          3'd2: count <= dd_s[7:0];
          3'd3: lba_lo <= dd_s[7:0];
          3'd4: lba_mid <= dd_s[7:0];
          3'd5: lba_hi <= dd_s[7:0];
          3'd6: device <= dd_s[7:0];
          default: ;
        endcase
      end
      if (cmd_wr) begin
        err <= !known;
        error[2] <= !known;
        SEC_CNT <= count == 8'h00 ? 9'd256 : {1'b0, count};
        LBA <= {device[3:0], lba_hi, lba_mid, lba_lo};
        CMD_WR <= dd_s[7:0] == 8'h30;
      end else if (wrap) SEC_CNT <= SEC_CNT - 9'd1;
      word_cnt <= (srst_on || cmd_wr) ? 8'h00 : xfer ? word_cnt + 8'h01 : word_cnt;
      pending <= pend_set ? 1'b1 : pend_clr ? 1'b0 : pending;
    end
  end
endmodule
